// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO, serving mfhi/mflo/mthi/mtlo.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 9-12).
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  MDU_op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        start,
  output logic        busy,
  output logic [31:0] result
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        is_compute, is_div, calc_wr;
  logic [63:0] calc_val;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, sden, sq, sr, q_s, r_s, uden, uq, ur;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
  assign prod_u = {32'd0, srcA} * {32'd0, srcB};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  assign a_mag = srcA[31] ? (~srcA + 32'd1) : srcA;
  assign b_mag = srcB[31] ? (~srcB + 32'd1) : srcB;
  assign sden  = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign sq    = a_mag / sden;
  assign sr    = a_mag % sden;
  assign q_s   = (srcA[31] ^ srcB[31]) ? (~sq + 32'd1) : sq;
  assign r_s   = srcA[31] ? (~sr + 32'd1) : sr;
  assign uden  = (srcB == 32'd0) ? 32'd1 : srcB;
  assign uq    = srcA / uden;
  assign ur    = srcA % uden;

  always_comb begin
    is_compute = 1'b0;
    is_div     = 1'b0;
    calc_wr    = 1'b1;
    calc_val   = 64'd0;
    case (MDU_op)
      OP_MULT:  begin is_compute = 1'b1; calc_val = prod_s; end
      OP_MULTU: begin is_compute = 1'b1; calc_val = prod_u; end
      OP_DIV: begin
        is_compute = 1'b1;
        is_div     = 1'b1;
        calc_val   = {r_s, q_s};
        calc_wr    = (srcB != 32'd0);
      end
      OP_DIVU: begin
        is_compute = 1'b1;
        is_div     = 1'b1;
        calc_val   = {ur, uq};
        calc_wr    = (srcB != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_compute = 1'b1; calc_val = {hi_q, lo_q} + prod_s; end
      OP_MADDU: begin is_compute = 1'b1; calc_val = {hi_q, lo_q} + prod_u; end
      OP_MSUB:  begin is_compute = 1'b1; calc_val = {hi_q, lo_q} - prod_s; end
      OP_MSUBU: begin is_compute = 1'b1; calc_val = {hi_q, lo_q} - prod_u; end
`endif
      default: ;
    endcase
  end

  assign start  = en & is_compute & ~busy_q;
  assign busy   = busy_q;
  assign result = (en && MDU_op == OP_MFHI) ? hi_q :
                  (en && MDU_op == OP_MFLO) ? lo_q : 32'd0;

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    if (busy_q) begin
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        cnt_d  = 4'd0;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (start) begin
      pend_hi_d = calc_val[63:32];
      pend_lo_d = calc_val[31:0];
      pend_wr_d = calc_wr;
      busy_d    = 1'b1;
      cnt_d     = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (en && MDU_op == OP_MTHI) begin
      hi_d = srcA;
    end else if (en && MDU_op == OP_MTLO) begin
      lo_d = srcA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= 4'd0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: arithmetic reference model plus literal spot checks.
// Build with +define+MDU_MADD_EN to exercise ops 9-12.
module tb_mdu;
  localparam int MULT = 5;
  localparam int DIV  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  MDU_op = 4'd0;
  logic [31:0] srcA = 32'd0;
  logic [31:0] srcB = 32'd0;
  logic        start, busy;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  mdu #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .reset(reset), .en(en), .MDU_op(MDU_op),
    .srcA(srcA), .srcB(srcB), .start(start), .busy(busy), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: HI/LO plus the edge index at which the in-flight op retires.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  bit          m_pwr = 1'b0;
  int          cyc = 0, done_edge = 0;

  function automatic bit is_comp(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  function automatic logic [63:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [63:0] acc, output bit wr);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    wr = 1'b1;
    r = 64'd0;
    case (op)
      4'd1: r = sa * sb;
      4'd2: r = ua * ub;
      4'd3: if (b == 32'd0) wr = 1'b0; else r = {32'(sa % sb), 32'(sa / sb)};
      4'd4: if (b == 32'd0) wr = 1'b0; else r = {32'(ua % ub), 32'(ua / ub)};
      4'd9:  r = acc + 64'(sa * sb);
      4'd10: r = acc + 64'(ua * ub);
      4'd11: r = acc - 64'(sa * sb);
      4'd12: r = acc - 64'(ua * ub);
      default: wr = 1'b0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [63:0] v;
    bit wr, busy_pre;
    int e;
    if (!reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0;
      m_pwr = 1'b0; done_edge = 0; cyc = 0;
    end else begin
      busy_pre = (cyc < done_edge);
      e = cyc + 1;
      if (busy_pre && e == done_edge && m_pwr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
      if (!busy_pre && en) begin
        if (is_comp(MDU_op)) begin
          v = calc(MDU_op, srcA, srcB, {m_hi, m_lo}, wr);
          m_phi = v[63:32];
          m_plo = v[31:0];
          m_pwr = wr;
          done_edge = e + ((MDU_op == 4'd3 || MDU_op == 4'd4) ? DIV : MULT);
        end else if (MDU_op == 4'd7) m_hi = srcA;
        else if (MDU_op == 4'd8) m_lo = srcA;
      end
      cyc = e;
    end
  end

  always @(negedge clk) begin
    bit be;
    logic [31:0] re;
    be = (cyc < done_edge);
    re = (en && MDU_op == 4'd5) ? m_hi : (en && MDU_op == 4'd6) ? m_lo : 32'd0;
    check("model_busy", 32'(busy), 32'(be));
    check("model_start", 32'(start), 32'(en && is_comp(MDU_op) && !be));
    check("model_result", result, re);
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #2;
    en = 1'b1; MDU_op = op; srcA = a; srcB = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      en = 1'b0; MDU_op = 4'd0; srcA = 32'd0; srcB = 32'd0;
    end
  endtask

  task automatic rd(input logic [3:0] op, input logic [31:0] exp, input string name);
    drive(op, 32'd0, 32'd0);
    #1;
    check(name, result, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    @(posedge clk); #2; reset = 1'b1;
    rd(4'd5, 32'd0, "reset_hi");
    rd(4'd6, 32'd0, "reset_lo");
    check("reset_busy", 32'(busy), 32'd0);

    drive(4'd1, 32'hFFFFFFFE, 32'd3);
    repeat (MULT) begin idle(1); #1; check("mult_busy_hi", 32'(busy), 32'd1); end
    drive(4'd5, 32'd0, 32'd0); #1;
    check("mult_busy_fall", 32'(busy), 32'd0);
    check("mult_hi", result, 32'hFFFFFFFF);
    rd(4'd6, 32'hFFFFFFFA, "mult_lo");

    drive(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF); idle(MULT);
    rd(4'd5, 32'hFFFFFFFE, "multu_hi");
    rd(4'd6, 32'h00000001, "multu_lo");

    drive(4'd3, 32'hFFFFFFF9, 32'd2); idle(DIV);
    rd(4'd6, 32'hFFFFFFFD, "div_lo");
    rd(4'd5, 32'hFFFFFFFF, "div_hi");
    drive(4'd4, 32'd7, 32'd0);
    repeat (DIV) begin idle(1); #1; check("div0_busy", 32'(busy), 32'd1); end
    rd(4'd6, 32'hFFFFFFFD, "div0_lo_kept");
    rd(4'd5, 32'hFFFFFFFF, "div0_hi_kept");

    drive(4'd3, 32'd7, 32'hFFFFFFFE); idle(DIV);
    rd(4'd6, 32'hFFFFFFFD, "div_neg_b_lo");
    rd(4'd5, 32'd1, "div_neg_b_hi");
    drive(4'd3, 32'h80000000, 32'hFFFFFFFF); idle(DIV);
    rd(4'd6, 32'h80000000, "div_ovf_lo");
    rd(4'd5, 32'd0, "div_ovf_hi");

    drive(4'd7, 32'h12345678, 32'd0);
    rd(4'd5, 32'h12345678, "mthi");
    drive(4'd1, 32'd3, 32'd5);
    repeat (MULT) drive(4'd1, 32'd100, 32'd100);
    drive(4'd6, 32'd0, 32'd0); #1;
    check("held_busy_fall", 32'(busy), 32'd0);
    check("held_lo", result, 32'd15);
    rd(4'd5, 32'd0, "held_hi");

    drive(4'd1, 32'd7, 32'd9); idle(MULT);
    drive(4'd1, 32'd2, 32'd3); #1;
    check("b2b_start", 32'(start), 32'd1);
    drive(4'd6, 32'd0, 32'd0); #1;
    check("b2b_busy_again", 32'(busy), 32'd1);
    check("b2b_prev_lo", result, 32'd63);
    idle(MULT - 1);
    rd(4'd6, 32'd6, "b2b_lo");

    drive(4'd7, 32'hAAAA5555, 32'd0);
    drive(4'd3, 32'd100, 32'd7); idle(3);
    @(posedge clk); #2;
    reset = 1'b0; en = 1'b1; MDU_op = 4'd5; #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_hi", result, 32'd0);
    MDU_op = 4'd6; #1;
    check("async_lo", result, 32'd0);
    idle(2);
    @(posedge clk); #2; reset = 1'b1;
    idle(DIV + 2);
    rd(4'd5, 32'd0, "no_late_hi");
    rd(4'd6, 32'd0, "no_late_lo");

`ifdef MDU_MADD_EN
    drive(4'd8, 32'd10, 32'd0);
    drive(4'd7, 32'd0, 32'd0);
    drive(4'd9, 32'd3, 32'd4); idle(MULT);
    rd(4'd6, 32'd22, "madd_lo");
    rd(4'd5, 32'd0, "madd_hi");
    drive(4'd12, 32'd1, 32'd23); idle(MULT);
    rd(4'd5, 32'hFFFFFFFF, "msubu_hi");
    rd(4'd6, 32'hFFFFFFFF, "msubu_lo");
`else
    drive(4'd8, 32'd10, 32'd0);
    drive(4'd9, 32'd3, 32'd4); #1;
    check("op9_no_start", 32'(start), 32'd0);
    idle(MULT + 1);
    rd(4'd6, 32'd10, "op9_lo_kept");
    rd(4'd5, 32'd0, "op9_hi_kept");
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the EX stage, alongside the ALU.
- Takes the same forwarded srcA/srcB operands as the ALU.
- Performs multi-cycle mult/multu/div/divu into private HI/LO registers, and serves mfhi/mflo/mthi/mtlo.
- Exports busy so the hazard unit can stall later MDU instructions in D.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10: busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- en  input  1  EX instruction valid and not flushed; qualifies MDU_op.
- MDU_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-12 optional feature, 13-15 none.
- srcA  input  32  rs operand.
- srcB  input  32  rt operand.
- start  output  1  combinational: en and MDU_op is a compute op (1-4, plus 9-12 when enabled) and busy=0.
- busy  output  1  registered; high while an operation is in flight.
- result  output  32  combinational: HI for mfhi, LO for mflo, else 0.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, counter=0, pending registers=0. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- Issue: start=1 at edge T.
  - Latch pending {HI',LO'} computed from srcA/srcB.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES); set busy=1.
- In flight: busy is high for exactly the N cycles following edge T; the counter decrements each edge.
- Completion: on the edge where counter goes 1→0, write HI/LO from pending and clear busy. The new HI/LO is visible on result in the first cycle busy=0.
- mult: {HI,LO} = signed 64-bit srcA*srcB.
- multu: {HI,LO} = unsigned 64-bit srcA*srcB.
- div: LO = quotient truncated toward zero; HI = remainder, which takes the sign of srcA.
  - Special case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: unsigned quotient to LO, unsigned remainder to HI.
- Divide by zero (srcB=0, div or divu): busy still runs DIV_CYCLES; HI/LO are left unchanged at completion.
- mthi/mtlo: when en=1 and busy=0, write srcA to HI/LO at the next edge; no busy.
- mfhi/mflo: purely combinational read of the current HI/LO; no state change.
- A compute op, mthi or mtlo presented while busy=1 is ignored (start=0, no write). The hazard unit guarantees it stalls these; ignoring them is the defined safety behaviour.
- en=0: MDU_op is ignored entirely; an in-flight operation continues.
- An op arriving in the same cycle busy falls (busy=0 that cycle) is accepted normally. This allows back-to-back issue: busy goes low for one cycle, then high again.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 9 madd, 10 maddu, 11 msub, 12 msubu are compute ops with MULT_CYCLES latency.
  - The completion value is {HI,LO} ± product, using the signed (9, 11) or unsigned (10, 12) 64-bit product.
  - {HI,LO} is sampled at issue; wraps mod 2^64.
- Undefined: ops 9-12 behave as op 0 (no start, no write, result=0).

Test Plan:
- Reset, then mult srcA=0xFFFFFFFE (-2), srcB=3 at T → busy high T+1..T+5; then mfhi=0xFFFFFFFF, mflo=0xFFFFFFFA.
- multu 0xFFFFFFFF*0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div srcA=-7 (0xFFFFFFF9), srcB=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 afterwards → HI/LO unchanged after 10 busy cycles.
- mthi 0x12345678, then mult issued while busy; a second mult held with en=1 during busy → second op ignored, HI/LO equal the first product only. Back-to-back mult on the busy-fall cycle → accepted, busy re-asserts.
- Assert reset=0 asynchronously at cycle 3 of a div → busy, HI, LO read 0 immediately with no clock edge; no late writeback after release.
- With MDU_MADD_EN: mtlo 10, mthi 0, then madd 3*4 → LO=22, HI=0. msubu 1*23 → {HI,LO}=0xFFFFFFFF_FFFFFFFF. Without the macro: MDU_OP=9 → start=0, HI/LO unchanged.
